// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM states, prefix bytes
// and the packed key-event layout {ext, brk, code}.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int EVT_W        = 10;
  localparam int EVT_EXT      = 9;
  localparam int EVT_BRK      = 8;
  localparam int EVT_CODE_MSB = 7;
  localparam int EVT_CODE_LSB = 0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head while not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the lines, frame-check each
// byte, fold E0/F0 prefixes into key events and queue them behind valid/ready.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [EVT_W-1:0]     evt_data,
  output logic                 overflow,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_err
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;
  assign raw_lines = {ps2_data, ps2_clk};

  // Line 0 is ps2_clk, line 1 is ps2_data; both idle high.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic           sync1_reg, sync2_reg, filt_reg;
      logic [FCW-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_lines[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FCW'(FILTER_LEN - 1)) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + FCW'(1);
          end
        end
      end
      assign filt_lines[gi] = filt_reg;
    end
  endgenerate

  logic clk_prev_reg;
  logic fall;
  logic din;
  assign fall = clk_prev_reg & ~filt_lines[0];
  assign din  = filt_lines[1];

  ps2_state_t    state_reg, state_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          frame_err;
  logic          byte_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_prev_reg <= 1'b1;
      state_reg    <= IDLE;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      tmo_reg      <= '0;
    end else begin
      clk_prev_reg <= filt_lines[0];
      state_reg    <= state_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      tmo_reg      <= tmo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    tmo_next     = '0;
    frame_err    = 1'b0;
    byte_ok      = 1'b0;
    if (state_reg != IDLE && !fall) tmo_next = tmo_reg + TW'(1);
    if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!din) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            frame_err = 1'b1;
          end
        end
        DATA: begin
          shift_next   = {din, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = din;
          state_next = STOP;
        end
        STOP: begin
          if (din && ps2_parity_ok(shift_reg, par_reg)) byte_ok = 1'b1;
          else frame_err = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
      state_next = IDLE;
      frame_err  = 1'b1;
      tmo_next   = '0;
    end
  end

  logic             ext_reg, brk_reg;
  logic             dec_valid_reg;
  logic [EVT_W-1:0] dec_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      dec_valid_reg <= 1'b0;
      dec_data_reg  <= '0;
    end else begin
      dec_valid_reg <= 1'b0;
      if (frame_err) begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end else if (byte_ok) begin
        if (shift_reg == PS2_PFX_EXT) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == PS2_PFX_BRK) begin
          brk_reg <= 1'b1;
        end else begin
          dec_valid_reg <= 1'b1;
          dec_data_reg  <= {ext_reg, brk_reg, shift_reg};
          ext_reg       <= 1'b0;
          brk_reg       <= 1'b0;
        end
      end
    end
  end

  logic fifo_full, fifo_empty, drop;

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dec_valid_reg),
    .din   (dec_data_reg),
    .pop   (evt_ready),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign drop      = dec_valid_reg & fifo_full & ~(evt_valid & evt_ready);

  // A clear that coincides with a new error/drop keeps that new event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      err_pulse <= frame_err;
      if (clr_err)                       err_cnt <= frame_err ? ERR_CNT_W'(1) : '0;
      else if (frame_err && ~&err_cnt)   err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (clr_err)   overflow <= drop;
      else if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames driven bit by bit, events
// captured by a consumer monitor and compared to hand-computed codes.
module tb_ps2_rx_fifo;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int FIFO_DEPTH  = 8;
  localparam int ERR_CNT_W   = 8;
  localparam int HALF        = 10;

  logic                 clk = 0;
  logic                 rst_n = 0;
  logic                 ps2_clk = 1;
  logic                 ps2_data = 1;
  logic                 evt_valid;
  logic                 evt_ready = 1;
  logic [9:0]           evt_data;
  logic                 overflow;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 clr_err = 0;

  ps2_rx_fifo #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH(FIFO_DEPTH), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow(overflow), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         stop_cyc = 0;
  int         last_rise = 0;
  int         vcyc = 0;
  int         epulses = 0;
  logic       valid_prev = 0;
  logic [9:0] got[$];
  int         n_chk = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer/monitor: sampled mid-cycle, a pop is what the next edge will do.
  always @(negedge clk) begin
    valid_prev <= evt_valid;
    if (evt_valid && !valid_prev) last_rise <= cyc;
    if (evt_valid) vcyc <= vcyc + 1;
    if (err_pulse) epulses <= epulses + 1;
    if (rst_n && evt_valid && evt_ready) got.push_back(evt_data);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits bits of an 11-bit frame; optional short ps2_clk glitch on bit 1.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && i == 1) begin
        wait_cyc(3);
        ps2_clk = 0;
        wait_cyc(2);
        ps2_clk = 1;
        wait_cyc(HALF - 5);
      end else begin
        wait_cyc(HALF);
      end
      if (i == 10) stop_cyc = cyc;
      ps2_clk = 0;
      wait_cyc(HALF);
      ps2_clk = 1;
    end
    ps2_data = 1;
    wait_cyc(HALF + 10);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  task automatic pulse_clr;
    clr_err = 1;
    wait_cyc(1);
    clr_err = 0;
    wait_cyc(1);
  endtask

  initial begin
    int n0, v0, e0;
    wait_cyc(3);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1;
    wait_cyc(5);

    // Single make code and pipeline latency from the stop-bit fall.
    n0 = got.size(); v0 = vcyc;
    good(8'h1C);
    check("1c_count", got.size() - n0, 1);
    check("1c_data", got[n0], 10'h01C);
    check("1c_valid_cycles", vcyc - v0, 1);
    check("1c_latency", last_rise - stop_cyc, 2 + FILTER_LEN + 2);
    check("1c_err_cnt", err_cnt, 0);

    n0 = got.size();
    good(8'hE0); good(8'hF0); good(8'h75);
    check("e0f075_count", got.size() - n0, 1);
    check("e0f075_data", got[n0], 10'h375);
    n0 = got.size();
    good(8'hF0); good(8'h5A);
    check("f05a_count", got.size() - n0, 1);
    check("f05a_data", got[n0], 10'h15A);

    // Parity error must also drop the pending E0 prefix.
    n0 = got.size(); e0 = epulses;
    good(8'hE0);
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    check("badpar_count", got.size() - n0, 0);
    check("badpar_pulses", epulses - e0, 1);
    check("badpar_err_cnt", err_cnt, 1);
    good(8'h76);
    check("after_err_data", got[n0], 10'h076);

    pulse_clr;
    check("clr_err_cnt", err_cnt, 0);

    // Timeout after start + 4 data bits.
    e0 = epulses;
    send_frame(8'hFF, 1'b0, 5, 1'b0);
    wait_cyc(TIMEOUT_CYC + 50);
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_pulses", epulses - e0, 1);
    n0 = got.size();
    good(8'h29);
    check("after_tmo_count", got.size() - n0, 1);
    check("after_tmo_data", got[n0], 10'h029);

    n0 = got.size();
    send_frame(8'h1C, 1'b0, 11, 1'b1);
    check("glitch_count", got.size() - n0, 1);
    check("glitch_data", got[n0], 10'h01C);

    // Overflow: 9 frames into an 8-deep queue with the consumer stalled.
    pulse_clr;
    evt_ready = 0;
    for (int k = 0; k < 9; k++) good(8'h10 + 8'(k));
    check("ovf_flag", overflow, 1);
    check("ovf_valid", evt_valid, 1);
    check("ovf_head", evt_data, 10'h010);
    n0 = got.size();
    evt_ready = 1;
    wait_cyc(20);
    check("drain_count", got.size() - n0, 8);
    for (int k = 0; k < 8; k++) check($sformatf("drain_%0d", k), got[n0 + k], 10'h010 + k);
    check("ovf_sticky", overflow, 1);
    pulse_clr;
    check("ovf_cleared", overflow, 0);

    // Start bit of 1 is an error; the counter saturates at all-ones.
    for (int k = 0; k < 260; k++) begin
      ps2_clk = 0; wait_cyc(6);
      ps2_clk = 1; wait_cyc(6);
    end
    wait_cyc(10);
    check("err_cnt_sat", err_cnt, 255);

    // Reset with a queued event loses it.
    evt_ready = 0;
    good(8'h33);
    check("queued_valid", evt_valid, 1);
    rst_n = 0;
    wait_cyc(2);
    check("rst_q_valid", evt_valid, 0);
    check("rst_q_data", evt_data, 0);
    check("rst_q_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, the successor to the fixed single-key decoder. It filters and samples the PS/2 clock/data pair, validates every 11-bit frame (start, odd parity, stop, inter-bit timeout) and folds the E0/F0 prefixes into 10-bit key events. Events are queued in a FIFO behind a valid/ready stream, so consumers such as the game-control logic lose no make/break codes. Error reporting and a sticky overflow flag are included.

Parameters:
FILTER_LEN, 4, consecutive equal clk samples needed before the filtered ps2_clk/ps2_data level changes (>=1)
TIMEOUT_CYC, 100000, clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted
FIFO_DEPTH, 8, event queue entries (power of 2, >=2)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_data  out  10  {ext, brk, code[7:0]} of FIFO head
overflow  out  1  sticky: an event was dropped because the FIFO was full
err_pulse  out  1  one-cycle pulse per rejected frame
err_cnt  out  ERR_CNT_W  saturating count of rejected frames
clr_err  in  1  clears err_cnt and overflow

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state changes occur on posedge clk only.
- Reset values: evt_valid=0, evt_data=0, overflow=0, err_pulse=0, err_cnt=0. FSM=IDLE, FIFO empty, prefix flags clear, timeout counter 0, filtered levels=1 (idle high).
- Input path: 2-flop synchroniser per line, then the filter. The filtered level takes the new value only after FILTER_LEN consecutive identical synchronised samples.
- A fall strobe is a 1-cycle pulse when filtered ps2_clk goes 1->0. On each strobe, filtered ps2_data is sampled.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 -> DATA, bit index=0. Strobe with data=1 -> stay in IDLE, error.
  - DATA: shift in LSB-first. Bit index 7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: frame is good if stop=1 and XOR(code, parity)=1. Good frame -> byte to decoder. Otherwise error. Always -> IDLE.
- Timeout: the counter runs in any non-IDLE state and resets on each strobe. Reaching TIMEOUT_CYC -> IDLE, error, partial byte discarded.
- Error: err_pulse=1 for one cycle. err_cnt increments, saturating at all-ones. Prefix flags are cleared.
- Decoder, per good byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - So E0 F0 75 -> 0x375, and 1C -> 0x01C.
- Latency: evt_valid rises exactly 2 cycles after the STOP strobe cycle when the FIFO was empty (decode register, then FIFO write).
- FIFO: show-ahead. evt_data is the head whenever evt_valid=1 and holds stable until popped. A pop occurs when evt_valid & evt_ready. Ordering is strict FIFO.
- Push when full and no pop in the same cycle: the event is dropped and overflow is set.
- Push and pop in the same cycle when full: both succeed, occupancy unchanged, no overflow.
- Push and pop in the same cycle when empty: no bypass; the new event appears the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1 bit count.
- clr_err: err_cnt is cleared and overflow is cleared.
  - If an error coincides with clr_err, err_cnt becomes 1.
  - If an overflow coincides with clr_err, overflow stays 1.
- rst_n low mid-frame or with the FIFO non-empty: all state returns to reset values and queued events are lost.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state enum {IDLE, DATA, PARITY, STOP}
  - constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0
  - EVT_W=10 and field positions EVT_EXT=9, EVT_BRK=8, EVT_CODE=7:0
- One sub-module: ps2_evt_fifo (parameters DEPTH, W), a synchronous show-ahead FIFO with full/empty/push/pop.

Test Plan:
- Frame 1C, parity 0, stop 1, evt_ready=1 -> evt_data=0x01C; evt_valid high 1 cycle exactly 2 cycles after the stop strobe; err_cnt=0.
- Frames E0, F0, 75 -> single event 0x375, no event for the prefix bytes. Frames F0, 5A -> 0x15A.
- Frame 1C with parity=1 -> no event, err_pulse one cycle, err_cnt=1. The next good frame 76 -> 0x076 with no stale prefix.
- Stop after 4 data bits, idle TIMEOUT_CYC cycles -> err_cnt=1, FSM back in IDLE. A following good frame is decoded correctly.
- FIFO_DEPTH=8, evt_ready=0, send 9 good frames -> 8 queued, overflow=1. Drain -> first 8 codes in order. clr_err -> overflow=0.
- Glitch on ps2_clk shorter than FILTER_LEN cycles mid-frame -> no extra bit; correct event emitted.
